iter_alu: RTL and testbench

ITER_ALU -- requirements
Module: iter_alu

---
 rtl/alu_pkg.sv | 30 +++
 rtl/iter_divider.sv | 83 ++++++++
 rtl/iter_alu.sv | 189 ++++++++++++++++++
 tb/tb_iter_alu.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode and control-state encodings for the iterative ALU and its decode stage.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_IINC  = 4'b0000,
    OP_IADD  = 4'b0001,
    OP_ISUB  = 4'b0010,
    OP_IMUL  = 4'b0011,
    OP_IDIV  = 4'b0100,
    OP_IREM  = 4'b0101,
    OP_IAND  = 4'b0110,
    OP_IOR   = 4'b0111,
    OP_IXOR  = 4'b1000,
    OP_INEG  = 4'b1001,
    OP_ISHL  = 4'b1010,
    OP_ISHR  = 4'b1011,
    OP_IUSHR = 4'b1100
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIVIDE = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  function automatic logic is_div_op(input op_e op);
    return (op == OP_IDIV) || (op == OP_IREM);
  endfunction

endpackage

// File: rtl/iter_divider.sv
// Unsigned restoring radix-2 divider: one quotient bit per cycle, WIDTH cycles per start.
module iter_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done_c,
  output logic [WIDTH-1:0] quotient_c,
  output logic [WIDTH-1:0] remainder_c
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic             q_bit;
  logic             last_c;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] quo_step;

  // quo_q starts as the dividend and shifts quotient bits in from the right
  always_comb begin
    rem_sh   = {rem_q, quo_q[WIDTH-1]};
    diff     = rem_sh - {1'b0, dsr_q};
    q_bit    = ~diff[WIDTH];
    rem_step = q_bit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    quo_step = {quo_q[WIDTH-2:0], q_bit};
    last_c   = busy_q && (cnt_q == CNT_W'(WIDTH - 1));

    busy_d = busy_q;
    cnt_d  = cnt_q;
    quo_d  = quo_q;
    rem_d  = rem_q;
    dsr_d  = dsr_q;

    if (start) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      quo_d  = dividend;
      rem_d  = '0;
      dsr_d  = divisor;
    end else if (busy_q) begin
      quo_d = quo_step;
      rem_d = rem_step;
      cnt_d = cnt_q + CNT_W'(1);
      if (last_c) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      dsr_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      dsr_q  <= dsr_d;
    end
  end

  assign busy        = busy_q;
  assign done_c      = last_c;
  assign quotient_c  = quo_step;
  assign remainder_c = rem_step;

endmodule

// File: rtl/iter_alu.sv
// Iterative integer ALU: single-cycle ops plus a multi-cycle signed divider,
// with valid/ready handshakes on both request and result sides.
module iter_alu #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [3:0]       op_select,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             div_by_zero,
  output logic             illegal_op
);

  import alu_pkg::*;

  state_e           state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             dbz_q, dbz_d;
  logic             ill_q, ill_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             is_rem_q, is_rem_d;

  op_e                     op_c;
  logic                    a_neg, b_neg;
  logic [WIDTH-1:0]        mag_a_c, mag_b_c;
  logic [SHAMT_W-1:0]      shamt;
  logic signed [2*WIDTH-1:0] a_ext, b_ext, prod;
  logic [WIDTH-1:0]        alu_lo, alu_hi;
  logic                    alu_dbz, alu_ill;

  logic                    div_start_c;
  logic                    div_busy;
  logic                    div_done_c;
  logic [WIDTH-1:0]        div_quo_c, div_rem_c;
  logic [WIDTH-1:0]        quo_fix, rem_fix;

  assign op_c    = op_e'(op_select);
  assign a_neg   = operand_a[WIDTH-1];
  assign b_neg   = operand_b[WIDTH-1];
  assign mag_a_c = a_neg ? -operand_a : operand_a;
  assign mag_b_c = b_neg ? -operand_b : operand_b;
  assign shamt   = operand_b[SHAMT_W-1:0];
  assign a_ext   = {{WIDTH{operand_a[WIDTH-1]}}, operand_a};
  assign b_ext   = {{WIDTH{operand_b[WIDTH-1]}}, operand_b};
  assign prod    = a_ext * b_ext;

  // Single-cycle datapath; divide opcodes only resolve the b == 0 case here
  always_comb begin
    alu_lo  = '0;
    alu_hi  = '0;
    alu_dbz = 1'b0;
    alu_ill = 1'b0;
    case (op_c)
      OP_IINC:  alu_lo = operand_a + WIDTH'(1);
      OP_IADD:  alu_lo = operand_a + operand_b;
      OP_ISUB:  alu_lo = operand_a - operand_b;
      OP_IMUL: begin
        alu_lo = prod[WIDTH-1:0];
        alu_hi = prod[2*WIDTH-1:WIDTH];
      end
      OP_IDIV, OP_IREM: alu_dbz = (operand_b == '0);
      OP_IAND:  alu_lo = operand_a & operand_b;
      OP_IOR:   alu_lo = operand_a | operand_b;
      OP_IXOR:  alu_lo = operand_a ^ operand_b;
      OP_INEG:  alu_lo = ~operand_a;
      OP_ISHL:  alu_lo = operand_a << shamt;
      OP_ISHR:  alu_lo = WIDTH'($signed(operand_a) >>> shamt);
      OP_IUSHR: alu_lo = operand_a >> shamt;
      default:  alu_ill = 1'b1;
    endcase
  end

  assign quo_fix = neg_quo_q ? -div_quo_c : div_quo_c;
  assign rem_fix = neg_rem_q ? -div_rem_c : div_rem_c;

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    dbz_d       = dbz_q;
    ill_d       = ill_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    is_rem_d    = is_rem_q;
    div_start_c = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (is_div_op(op_c) && (operand_b != '0)) begin
            div_start_c = 1'b1;
            neg_quo_d   = a_neg ^ b_neg;
            neg_rem_d   = a_neg;
            is_rem_d    = (op_c == OP_IREM);
            state_d     = ST_DIVIDE;
          end else begin
            lo_d        = alu_lo;
            hi_d        = alu_hi;
            dbz_d       = alu_dbz;
            ill_d       = alu_ill;
            out_valid_d = 1'b1;
            state_d     = ST_DONE;
          end
        end
      end
      ST_DIVIDE: begin
        if (div_done_c) begin
          lo_d        = is_rem_q ? rem_fix : quo_fix;
          hi_d        = '0;
          dbz_d       = 1'b0;
          ill_d       = 1'b0;
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end else if (!div_busy) begin
          // Divider lost its operation; recover rather than wait forever
          state_d = ST_IDLE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    in_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      lo_q        <= '0;
      hi_q        <= '0;
      dbz_q       <= 1'b0;
      ill_q       <= 1'b0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      is_rem_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      dbz_q       <= dbz_d;
      ill_q       <= ill_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      is_rem_q    <= is_rem_d;
    end
  end

  iter_divider #(.WIDTH(WIDTH)) u_divider (
    .clk         (clk),
    .rst         (rst),
    .start       (div_start_c),
    .dividend    (mag_a_c),
    .divisor     (mag_b_c),
    .busy        (div_busy),
    .done_c      (div_done_c),
    .quotient_c  (div_quo_c),
    .remainder_c (div_rem_c)
  );

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign result_lo   = lo_q;
  assign result_hi   = hi_q;
  assign div_by_zero = dbz_q;
  assign illegal_op  = ill_q;

endmodule

// File: tb/tb_iter_alu.sv
// Directed-vector bench for iter_alu at WIDTH=32 with hand-computed expectations.
module tb_iter_alu;

  localparam int unsigned W = 32;

  typedef struct packed {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         dbz;
    int           lat;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] operand_a;
  logic [W-1:0] operand_b;
  logic [3:0]   op_select;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result_lo;
  logic [W-1:0] result_hi;
  logic         div_by_zero;
  logic         illegal_op;

  int vectors    = 0;
  int miscompares = 0;

  iter_alu #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .op_select   (op_select),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result_lo   (result_lo),
    .result_hi   (result_hi),
    .div_by_zero (div_by_zero),
    .illegal_op  (illegal_op)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, scramble the inputs after acceptance, and count edges until out_valid
  task automatic do_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int lat);
    int guard = 0;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    op_select = op;
    operand_a = a;
    operand_b = b;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
    operand_a = ~a;
    operand_b = '0;
    op_select = 4'hF;
    lat = 1;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    if (!out_valid) lat = 99;
  endtask

  task automatic finish_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    op_select = 4'h1; operand_a = 32'd1; operand_b = 32'd2;
    tick();
    tick();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset out_valid got %b exp 0", out_valid); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset in_ready got %b exp 1", in_ready); end
    vectors++; if (result_lo !== '0) begin miscompares++; $display("FAIL reset result_lo got %h exp 0", result_lo); end
    vectors++; if (result_hi !== '0) begin miscompares++; $display("FAIL reset result_hi got %h exp 0", result_hi); end
    vectors++; if ({div_by_zero, illegal_op} !== 2'b00) begin miscompares++; $display("FAIL reset flags got %b exp 00", {div_by_zero, illegal_op}); end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_alu_ops();
    vec_t v[$];
    int lat;
    v.push_back('{4'h0, 32'h0000_0005, 32'h0000_0000, 32'h0000_0006, 32'h0, 1'b0, 1});
    v.push_back('{4'h0, 32'hFFFF_FFFF, 32'h1234_5678, 32'h0000_0000, 32'h0, 1'b0, 1});
    v.push_back('{4'h1, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 32'h0, 1'b0, 1});
    v.push_back('{4'h2, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 32'h0, 1'b0, 1});
    v.push_back('{4'h6, 32'hF0F0_FFFF, 32'h0FF0_00FF, 32'h00F0_00FF, 32'h0, 1'b0, 1});
    v.push_back('{4'h7, 32'h0F00_0000, 32'h0000_00F1, 32'h0F00_00F1, 32'h0, 1'b0, 1});
    v.push_back('{4'h8, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 32'h0, 1'b0, 1});
    v.push_back('{4'h9, 32'h0F0F_0F0F, 32'hFFFF_FFFF, 32'hF0F0_F0F0, 32'h0, 1'b0, 1});
    v.push_back('{4'h3, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0, 1});
    v.push_back('{4'h3, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 32'h0000_0001, 1'b0, 1});
    v.push_back('{4'h3, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 32'h4000_0000, 1'b0, 1});
    v.push_back('{4'h3, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 32'hFFFF_FFFF, 1'b0, 1});
    v.push_back('{4'hB, 32'h8000_0000, 32'd36,        32'hF800_0000, 32'h0, 1'b0, 1});
    v.push_back('{4'hC, 32'h8000_0000, 32'd36,        32'h0800_0000, 32'h0, 1'b0, 1});
    v.push_back('{4'hA, 32'h0000_0001, 32'd31,        32'h8000_0000, 32'h0, 1'b0, 1});
    v.push_back('{4'hA, 32'h0000_0003, 32'd33,        32'h0000_0006, 32'h0, 1'b0, 1});
    foreach (v[i]) begin
      do_op(v[i].op, v[i].a, v[i].b, lat);
      vectors++; if (lat !== v[i].lat) begin miscompares++; $display("FAIL alu_ops[%0d] latency got %0d exp %0d", i, lat, v[i].lat); end
      vectors++; if (result_lo !== v[i].lo) begin miscompares++; $display("FAIL alu_ops[%0d] result_lo got %h exp %h", i, result_lo, v[i].lo); end
      vectors++; if (result_hi !== v[i].hi) begin miscompares++; $display("FAIL alu_ops[%0d] result_hi got %h exp %h", i, result_hi, v[i].hi); end
      vectors++; if ({div_by_zero, illegal_op} !== 2'b00) begin miscompares++; $display("FAIL alu_ops[%0d] flags got %b exp 00", i, {div_by_zero, illegal_op}); end
      finish_out();
    end
  endtask

  task automatic test_divide();
    vec_t v[$];
    int lat;
    v.push_back('{4'h4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 32'h0, 1'b0, 33});
    v.push_back('{4'h5, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'h0, 1'b0, 33});
    v.push_back('{4'h4, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0, 1'b0, 33});
    v.push_back('{4'h5, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'h0, 1'b0, 33});
    v.push_back('{4'h4, 32'd100,       32'd7,         32'd14,        32'h0, 1'b0, 33});
    v.push_back('{4'h5, 32'd100,       32'd7,         32'd2,         32'h0, 1'b0, 33});
    v.push_back('{4'h4, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14,        32'h0, 1'b0, 33});
    v.push_back('{4'h5, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'h0, 1'b0, 33});
    v.push_back('{4'h4, 32'd3,         32'd10,        32'd0,         32'h0, 1'b0, 33});
    v.push_back('{4'h5, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b0, 33});
    v.push_back('{4'h4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 1'b0, 33});
    v.push_back('{4'h5, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0, 1'b0, 33});
    v.push_back('{4'h4, 32'd5,         32'd0,         32'd0,         32'h0, 1'b1, 1});
    v.push_back('{4'h5, 32'hFFFF_FFF9, 32'd0,         32'd0,         32'h0, 1'b1, 1});
    foreach (v[i]) begin
      do_op(v[i].op, v[i].a, v[i].b, lat);
      vectors++; if (lat !== v[i].lat) begin miscompares++; $display("FAIL divide[%0d] latency got %0d exp %0d", i, lat, v[i].lat); end
      vectors++; if (result_lo !== v[i].lo) begin miscompares++; $display("FAIL divide[%0d] result_lo got %h exp %h", i, result_lo, v[i].lo); end
      vectors++; if (result_hi !== v[i].hi) begin miscompares++; $display("FAIL divide[%0d] result_hi got %h exp %h", i, result_hi, v[i].hi); end
      vectors++; if (div_by_zero !== v[i].dbz) begin miscompares++; $display("FAIL divide[%0d] div_by_zero got %b exp %b", i, div_by_zero, v[i].dbz); end
      vectors++; if (illegal_op !== 1'b0) begin miscompares++; $display("FAIL divide[%0d] illegal_op got %b exp 0", i, illegal_op); end
      finish_out();
    end
  endtask

  task automatic test_illegal();
    int lat;
    logic [3:0] op;
    for (int k = 13; k <= 15; k++) begin
      op = 4'(k);
      do_op(op, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
      vectors++; if (lat !== 1) begin miscompares++; $display("FAIL illegal[%0d] latency got %0d exp 1", k, lat); end
      vectors++; if (illegal_op !== 1'b1) begin miscompares++; $display("FAIL illegal[%0d] illegal_op got %b exp 1", k, illegal_op); end
      vectors++; if ({result_hi, result_lo} !== 64'h0) begin miscompares++; $display("FAIL illegal[%0d] result got %h exp 0", k, {result_hi, result_lo}); end
      vectors++; if (div_by_zero !== 1'b0) begin miscompares++; $display("FAIL illegal[%0d] div_by_zero got %b exp 0", k, div_by_zero); end
      finish_out();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    do_op(4'h1, 32'd10, 32'd20, lat);
    vectors++; if (lat !== 1) begin miscompares++; $display("FAIL backpressure latency got %0d exp 1", lat); end
    // Offer a competing request while the result is held; it must not disturb anything
    in_valid = 1'b1; op_select = 4'h2; operand_a = 32'd99; operand_b = 32'd1;
    for (int c = 0; c < 5; c++) begin
      vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL hold[%0d] out_valid got %b exp 1", c, out_valid); end
      vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL hold[%0d] in_ready got %b exp 0", c, in_ready); end
      vectors++; if ({result_hi, result_lo} !== 64'd30) begin miscompares++; $display("FAIL hold[%0d] result got %h exp 1e", c, {result_hi, result_lo}); end
      vectors++; if ({div_by_zero, illegal_op} !== 2'b00) begin miscompares++; $display("FAIL hold[%0d] flags got %b exp 00", c, {div_by_zero, illegal_op}); end
      tick();
    end
    in_valid = 1'b0;
    finish_out();
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL release in_ready got %b exp 1", in_ready); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL release out_valid got %b exp 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1; in_valid = 1'b1; op_select = 4'h1; operand_b = 32'd1;
    for (int k = 0; k < 4; k++) begin
      operand_a = 32'(k * 10);
      tick();
      vectors++; if (out_valid !== 1'b1 || result_lo !== 32'(k * 10 + 1)) begin miscompares++; $display("FAIL b2b[%0d] accept valid/lo got %b/%h exp 1/%h", k, out_valid, result_lo, 32'(k * 10 + 1)); end
      vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL b2b[%0d] in_ready after accept got %b exp 0", k, in_ready); end
      tick();
      vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b[%0d] transfer valid/ready got %b/%b exp 0/1", k, out_valid, in_ready); end
    end
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_reset_abort();
    int lat;
    bit seen = 1'b0;
    op_select = 4'h4; operand_a = 32'd100; operand_b = 32'd3; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL abort in_ready got %b exp 1", in_ready); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL abort out_valid got %b exp 0", out_valid); end
    repeat (40) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL abort stray out_valid got %b exp 0", seen); end
    do_op(4'h1, 32'd3, 32'd4, lat);
    vectors++; if (lat !== 1) begin miscompares++; $display("FAIL post_abort latency got %0d exp 1", lat); end
    vectors++; if (result_lo !== 32'd7) begin miscompares++; $display("FAIL post_abort result_lo got %h exp 7", result_lo); end
    finish_out();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op_select = '0; operand_a = '0; operand_b = '0;
    test_reset();
    test_alu_ops();
    test_divide();
    test_illegal();
    test_backpressure();
    test_back_to_back();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
